// File: rtl/hilo_mult_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: state encoding,
// default operand width and the decoder funct codes that drive it.
package hilo_mult_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

endpackage

// File: rtl/hilo_mult_sequencer_if.sv
// Core-side bundle between the decoder/datapath and the HI/LO sequencer.
interface hilo_mult_sequencer_if
    import hilo_mult_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             readhi;
    logic             readlo;
    logic             abort;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, srca, srcb, readhi, readlo, abort,
        input  stall, busy, done, hi, lo
    );

    modport slave (
        input  start, srca, srcb, readhi, readlo, abort,
        output stall, busy, done, hi, lo
    );

endinterface

// File: rtl/hilo_mult_sequencer_mult_step.sv
// One shift-add step: conditionally add the multiplicand into the upper
// half (carry kept in the top bit), then shift the accumulator right by one.
module hilo_mult_sequencer_mult_step
    import hilo_mult_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH:0] acc,
    input  logic [WIDTH-1:0] mcand,
    output logic [2*WIDTH:0] acc_next
);

    logic [WIDTH:0] upper_sum;

    always_comb begin
        upper_sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        acc_next  = {1'b0, upper_sum, acc[WIDTH-1:1]};
    end

endmodule

// File: rtl/hilo_mult_sequencer.sv
// Multi-cycle unsigned MULTU unit owning HI/LO; stalls mfhi/mflo/MULTU
// while a product is pending.
module hilo_mult_sequencer
    import hilo_mult_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    hilo_mult_sequencer_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH:0] acc;
    logic [2*WIDTH:0] acc_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;

    hilo_mult_sequencer_mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            mcand  <= '0;
            acc    <= '0;
            count  <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand <= bus.srca;
                        acc   <= {{(WIDTH+1){1'b0}}, bus.srcb};
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // abort wins over completion, so an aborted last step never writes HI/LO
                    if (bus.abort) begin
                        state <= IDLE;
                    end else begin
                        acc   <= acc_next;
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            hi_r   <= acc_next[2*WIDTH-1:WIDTH];
                            lo_r   <= acc_next[WIDTH-1:0];
                            done_r <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.stall = bus.busy & (bus.start | bus.readhi | bus.readlo);
    assign bus.done  = done_r;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Scenario bench for hilo_mult_sequencer: expected products are queued at
// issue and popped when the sequencer reports completion.
module tb_hilo_mult_sequencer;
    import hilo_mult_sequencer_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic clk = 1'b0;
    logic reset = 1'b0;

    hilo_mult_sequencer_if #(.WIDTH(W)) bus ();

    hilo_mult_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2*W-1:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_funct(input logic [5:0] f, input bit valid);
        bus.start  = valid && (f == FUNCT_MULTU);
        bus.readhi = valid && (f == FUNCT_MFHI);
        bus.readlo = valid && (f == FUNCT_MFLO);
    endtask

    // Present MULTU for one edge from IDLE and queue the exact product.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.srca = a;
        bus.srcb = b;
        set_funct(FUNCT_MULTU, 1'b1);
        exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
        tick();
        set_funct(6'd0, 1'b0);
    endtask

    task automatic wait_done(input int budget, output int busy_cyc, output bit seen);
        busy_cyc = 0;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_cyc++;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [2*W-1:0] got;
        reset = 1'b0;
        set_funct(6'd0, 1'b0);
        bus.abort = 1'b0;
        bus.srca = '0;
        bus.srcb = '0;
        #12;
        got = {bus.hi, bus.lo};
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_hilo: got %h expected 0", got);
        end
        n_cmp++;
        if ({bus.busy, bus.done, bus.stall} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got busy/done/stall %b expected 000", {bus.busy, bus.done, bus.stall});
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_small();
        int cyc;
        bit seen;
        logic [2*W-1:0] e;
        bus.srca = 32'd3;
        bus.srcb = 32'd5;
        set_funct(FUNCT_MULTU, 1'b1);
        #1;
        n_cmp++;
        if (bus.stall !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_start_stall: got %b expected 0", bus.stall);
        end
        set_funct(6'd0, 1'b0);
        issue(32'd3, 32'd5);
        wait_done(40, cyc, seen);
        n_cmp++;
        if (!seen || cyc != 32) begin
            n_bad++;
            $display("FAIL small_latency: got busy %0d seen %0d expected 32 seen 1", cyc, seen);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.hi, bus.lo} !== e || e !== 64'h0000_0000_0000_000F) begin
            n_bad++;
            $display("FAIL small_product: got %h expected %h", {bus.hi, bus.lo}, 64'hF);
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL small_done_pulse: got %b expected 0", bus.done);
        end
        set_funct(FUNCT_MFLO, 1'b1);
        #1;
        n_cmp++;
        if (bus.stall !== 1'b0 || bus.lo !== 32'h0000_000F) begin
            n_bad++;
            $display("FAIL idle_mflo: got stall %b lo %h expected 0 0000000f", bus.stall, bus.lo);
        end
        set_funct(6'd0, 1'b0);
    endtask

    task automatic test_max();
        int cyc;
        bit seen;
        logic [2*W-1:0] e;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(40, cyc, seen);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || {bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001 || {bus.hi, bus.lo} !== e) begin
            n_bad++;
            $display("FAIL max_product: got %h seen %0d expected fffffffe00000001", {bus.hi, bus.lo}, seen);
        end
    endtask

    task automatic test_read_stall();
        int cnt;
        logic [2*W-1:0] e;
        issue(32'h1234_5678, 32'h9ABC_DEF0);
        tick();
        set_funct(FUNCT_MFHI, 1'b1);
        #1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            if (bus.stall) cnt++;
            tick();
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (cnt != 31) begin
            n_bad++;
            $display("FAIL mfhi_stall_cycles: got %0d expected 31", cnt);
        end
        n_cmp++;
        if (bus.stall !== 1'b0 || bus.done !== 1'b1 || bus.hi !== e[2*W-1:W]) begin
            n_bad++;
            $display("FAIL mfhi_release: got stall %b done %b hi %h expected 0 1 %h", bus.stall, bus.done, bus.hi, e[2*W-1:W]);
        end
        set_funct(6'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int cnt;
        int cyc;
        bit seen;
        logic [2*W-1:0] e;
        issue(32'd2, 32'd3);
        bus.srca = 32'd7;
        bus.srcb = 32'd9;
        set_funct(FUNCT_MULTU, 1'b1);
        #1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            if (bus.stall) cnt++;
            tick();
        end
        n_cmp++;
        if (cnt != 32 || bus.stall !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_stall: got %0d cycles final stall %b expected 32 0", cnt, bus.stall);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.hi, bus.lo} !== e || e !== 64'd6) begin
            n_bad++;
            $display("FAIL b2b_first: got %h expected %h", {bus.hi, bus.lo}, 64'd6);
        end
        exp_q.push_back(64'd63);
        tick();
        set_funct(6'd0, 1'b0);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_restart: got busy %b expected 1", bus.busy);
        end
        wait_done(40, cyc, seen);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || cyc != 32 || {bus.hi, bus.lo} !== e) begin
            n_bad++;
            $display("FAIL b2b_second: got %h busy %0d expected %h busy 32", {bus.hi, bus.lo}, cyc, e);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        bit seen;
        logic [2*W-1:0] e;
        issue(32'd2, 32'h8000_0001);
        wait_done(40, cyc, seen);
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.hi, bus.lo} !== e || e !== 64'h0000_0001_0000_0002) begin
            n_bad++;
            $display("FAIL pre_reset_product: got %h expected 0000000100000002", {bus.hi, bus.lo});
        end
        issue(32'd5, 32'd6);
        repeat (9) tick();
        void'(exp_q.pop_back());
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.hi, bus.lo} !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got hilo %h busy %b done %b expected 0 0 0", {bus.hi, bus.lo}, bus.busy, bus.done);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        issue(32'd11, 32'd13);
        wait_done(40, cyc, seen);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || cyc != 32 || {bus.hi, bus.lo} !== e || e !== 64'd143) begin
            n_bad++;
            $display("FAIL post_reset_product: got %h busy %0d expected 143 busy 32", {bus.hi, bus.lo}, cyc);
        end
    endtask

    task automatic test_abort();
        int cyc;
        bit seen;
        logic [2*W-1:0] e;
        issue(32'd3, 32'd5);
        wait_done(40, cyc, seen);
        void'(exp_q.pop_front());
        issue(32'h0000_FFFF, 32'h0000_FFFF);
        repeat (31) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        void'(exp_q.pop_back());
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || {bus.hi, bus.lo} !== 64'd15) begin
            n_bad++;
            $display("FAIL abort_last: got busy %b done %b hilo %h expected 0 0 f", bus.busy, bus.done, {bus.hi, bus.lo});
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %b expected 0", bus.done);
        end
        bus.abort = 1'b1;
        issue(32'd100, 32'd200);
        bus.abort = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_idle_ignored: got busy %b expected 1", bus.busy);
        end
        wait_done(40, cyc, seen);
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.hi, bus.lo} !== e || e !== 64'd20000) begin
            n_bad++;
            $display("FAIL abort_idle_product: got %h expected %h", {bus.hi, bus.lo}, 64'd20000);
        end
    endtask

    task automatic test_random();
        int cyc;
        bit seen;
        logic [2*W-1:0] e;
        for (int k = 0; k < 4; k++) begin
            issue(W'($urandom), W'($urandom));
            wait_done(40, cyc, seen);
            e = exp_q.pop_front();
            n_cmp++;
            if (!seen || {bus.hi, bus.lo} !== e) begin
                n_bad++;
                $display("FAIL random_%0d: got %h expected %h", k, {bus.hi, bus.lo}, e);
            end
            tick();
        end
    endtask

    initial begin
        bus.abort = 1'b0;
        test_reset();
        test_small();
        test_max();
        tick();
        test_read_stall();
        tick();
        test_back_to_back();
        tick();
        test_reset_mid_run();
        tick();
        test_abort();
        tick();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hilo_mult_sequencer.md
Name: hilo_mult_sequencer

Overview:
- Multi-cycle unsigned multiplier that owns the HI/LO register pair for the MIPS core.
- Sequences a shift-add multiply when the decoder asserts writehilo (MULTU).
- Serves mfhi/mflo reads when the decoder asserts loadhi/loadlo.
- Stalls the core while a product is pending, replacing the single-cycle ALU multiply path (alucontrol 3'b011).

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits, split into HI (upper) and LO (lower).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  MULTU issue (decoder writehilo).
- srca  in  WIDTH  multiplicand (rs).
- srcb  in  WIDTH  multiplier (rt).
- readhi  in  1  mfhi request (decoder loadhi).
- readlo  in  1  mflo request (decoder loadlo).
- abort  in  1  synchronous cancel of an in-flight multiply.
- stall  out  1  hold PC and instruction, suppress regwrite this cycle.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse in the cycle after HI/LO are updated.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: while reset=0, asynchronously force state=IDLE, hi=0, lo=0, internal accumulator and count=0, busy=0, done=0. Reset mid-RUN discards the multiply.
- State machine: two states, IDLE and RUN.
- IDLE:
  - With start=1 at an edge: latch srca into mcand, latch srcb into the LO half of a 2*WIDTH+1 accumulator, clear the upper half, set count=0, go to RUN.
  - With start=0: stay in IDLE.
- RUN, one step per cycle:
  - If acc[0]=1, upper = upper + mcand, with the carry kept in bit 2*WIDTH.
  - Then shift the whole accumulator right by 1 and increment count.
  - At the edge where count==WIDTH-1: write hi=acc[2*WIDTH-1:WIDTH] and lo=acc[WIDTH-1:0] from the final shifted value, then go to IDLE.
- Latency: busy is high for exactly WIDTH cycles after the start edge. hi/lo hold the new product in the first IDLE cycle, and done=1 in that same cycle.
- Outputs: busy = (state==RUN). hi/lo are registered and change only at completion or reset.
- stall = busy & (start | readhi | readlo).
  - A mfhi/mflo or a second MULTU presented during RUN stalls until the cycle after completion.
  - That instruction then proceeds; a re-presented start is accepted at that edge.
- start in IDLE never stalls; the MULTU instruction retires in its issue cycle.
- readhi/readlo in IDLE return the current hi/lo combinationally via the outputs, with no stall.
- Simultaneous readhi and readlo are not legal decode output, but stall handles them identically.
- abort=1 in RUN: go to IDLE at the next edge, hi/lo unchanged, no done pulse. abort has priority over completion in the last RUN cycle. abort in IDLE is ignored, including when start=1 in the same cycle.
- start during RUN (stalled) is ignored by the datapath; operands are not re-latched.
- Arithmetic: unsigned only. The carry bit prevents overflow of the upper-half add. The 2*WIDTH result is exact for all inputs.

Decomposition:
- Shared package holds:
  - the state encoding constants, IDLE=1'b0 and RUN=1'b1;
  - the default WIDTH=32;
  - the decoder funct codes for MULTU (6'b011001), MFHI (6'b010000) and MFLO (6'b010010).
- One natural sub-module, mult_step: combinational add-and-shift of the accumulator by one bit, instantiated once.

Test Plan:
- start with srca=3, srcb=5 -> busy high 32 cycles; hi=0x00000000, lo=0x0000000F; done pulses once.
- srca=0xFFFFFFFF, srcb=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 32 cycles.
- readhi asserted 1 cycle after start -> stall=1 for 31 cycles, 0 in the first IDLE cycle with hi valid.
- Second start held during RUN (srca=7, srcb=9 after 2x3) -> first product hi=0, lo=6; stall until completion; second product lo=63 after 32 more cycles.
- reset pulled low at cycle 10 of RUN with hi/lo previously 0x1/0x2 -> immediately hi=0, lo=0, busy=0; next start runs normally.
- abort at cycle 31 of RUN after prior product hi=0, lo=15 -> IDLE, hi=0, lo=15 unchanged, no done pulse.
